down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 32: width of load value, count and reload register.
REQ-002 SHALL have parameter EXP_CNT_WIDTH, default 16: width of the expiry event counter.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port r_reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_load_valid, input, 1: load request.
REQ-006 SHALL have port o_load_ready, output, 1: load can be accepted this cycle.
REQ-007 SHALL have port i_load_value, input, COUNT_WIDTH: terminal count N.
REQ-008 SHALL have port i_auto_reload, input, 1: periodic mode flag, sampled with the load.
REQ-009 SHALL have port i_start, input, 1: begin countdown.
REQ-010 SHALL have port i_stop, input, 1: abort to IDLE.
REQ-011 SHALL have port o_count, output, COUNT_WIDTH: current count, registered.
REQ-012 SHALL have port o_busy, output, 1: high in RUN or DONE.
REQ-013 SHALL have port o_expire, output, 1: one-cycle pulse, high exactly while the state is DONE.
REQ-014 SHALL have port o_exp_cnt, output, EXP_CNT_WIDTH: number of expiries, wrapping modulo 2^EXP_CNT_WIDTH.

Function
REQ-015 SHALL implement FSM states IDLE, ARMED, RUN, DONE.
REQ-016 o_load_ready SHALL be 1 in IDLE and ARMED and 0 in RUN, in DONE, and while r_reset is high.
REQ-017 Load handshake (i_load_valid & o_load_ready at an edge) SHALL set count and reload register to i_load_value, latch i_auto_reload, and go to ARMED.
REQ-018 i_start SHALL be honoured only in ARMED; start in IDLE SHALL be ignored.
REQ-019 Load and start at the same edge in ARMED SHALL move to RUN with the new value.
REQ-020 Load and start at the same edge in IDLE SHALL load only, going to ARMED.
REQ-021 Start in ARMED with count > 0 SHALL go to RUN with count unchanged.
REQ-022 Start in ARMED with count = 0 SHALL go directly to DONE.
REQ-023 In RUN with count > 1, count SHALL decrement by 1 per edge.
REQ-024 In RUN with count = 1, count SHALL become 0 and the state SHALL go to DONE.
REQ-025 Expiry SHALL occur exactly N edges after the edge sampling i_start, with o_expire high the following cycle.
REQ-026 DONE SHALL last one cycle, and o_exp_cnt SHALL increment on the edge leaving DONE.
REQ-027 Leaving DONE with auto-reload set SHALL go to RUN with count = reload value, or to DONE again if the reload value is 0 (expire every cycle).
REQ-028 Leaving DONE without auto-reload SHALL go to IDLE with count held at 0.
REQ-029 i_stop SHALL take priority over start and load and SHALL move any state to IDLE with count = 0, clear the auto-reload flag and raise no expire.
REQ-030 i_stop asserted in DONE SHALL still count that expiry in o_exp_cnt.
REQ-031 Decrement SHALL never underflow, so count wrap-around below 0 SHALL be impossible.
REQ-032 Arithmetic SHALL be unsigned at COUNT_WIDTH.

Reset
REQ-033 r_reset high at an edge SHALL force state IDLE, count 0, reload 0, auto-reload 0, o_expire 0, o_busy 0 and o_exp_cnt 0, overriding all inputs.
REQ-034 Reset asserted mid-RUN SHALL abort with no expire pulse.

Structure
REQ-035 Package down_counter_pkg SHALL hold the state enum typedef and the default COUNT_WIDTH and EXP_CNT_WIDTH constants.
REQ-036 One sub-module, down_counter_dp, SHALL hold the count and reload registers and the is-zero/is-one detects, with the FSM and o_exp_cnt in the top level.

Verification
REQ-037 Load 3, start next cycle -> count 3,2,1,0 on successive edges; o_expire high one cycle, 3 edges after the start edge; then IDLE; o_exp_cnt = 1.
REQ-038 Load 2 with auto-reload, start -> o_expire every 3rd cycle repeatedly; after 4 pulses o_exp_cnt = 4.
REQ-039 Load 0, start -> DONE on the next edge; with auto-reload, o_expire stays high every cycle until i_stop.
REQ-040 Load 100, start, then i_stop and i_load_valid together at count 50 -> IDLE, count 0, load not taken, no expire.
REQ-041 r_reset pulsed at count 5 of a load-10 run -> all outputs zero, o_load_ready 1 after reset deasserts, o_exp_cnt unchanged at 0.
REQ-042 Drive o_exp_cnt to 16'hFFFF, then one more expiry -> o_exp_cnt wraps to 0.

Source files
------------

// File: rtl/down_counter_pkg.sv
// down_counter_pkg
//   Shared definitions for the down_counter block: FSM state encoding and
//   default widths for the count and the expiry event counter.
package down_counter_pkg;

    localparam int DEF_COUNT_WIDTH   = 32;
    localparam int DEF_EXP_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/down_counter_dp.sv
// down_counter_dp
//   Count / reload datapath for down_counter. Holds the live count and the
//   reload value and provides the zero/one detects the FSM steers on.
//
//   Ports:
//     clk          clock, rising edge
//     r_reset      synchronous active-high reset (count and reload to 0)
//     load         take load_value into count and reload register
//     load_value   value to load
//     dec          decrement count by one (saturates at 0)
//     reload       copy reload register into count
//     clear        force count to 0 (highest priority)
//     count        current count
//     is_zero      count == 0
//     is_one       count == 1
//     reload_zero  reload register == 0
module down_counter_dp
    import down_counter_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   r_reset,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    input  logic                   dec,
    input  logic                   reload,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   is_zero,
    output logic                   is_one,
    output logic                   reload_zero
);

    logic [COUNT_WIDTH-1:0] reload_val;

    assign is_zero     = (count == '0);
    assign is_one      = (count == COUNT_WIDTH'(1));
    assign reload_zero = (reload_val == '0);

    always_ff @(posedge clk) begin
        if (r_reset) begin
            count      <= '0;
            reload_val <= '0;
        end else begin
            if (clear) begin
                count <= '0;
            end else if (load) begin
                count <= load_value;
            end else if (reload) begin
                count <= reload_val;
            end else if (dec && !is_zero) begin
                // guarded so the count can never wrap below zero
                count <= count - COUNT_WIDTH'(1);
            end

            if (load && !clear) begin
                reload_val <= load_value;
            end
        end
    end

endmodule

// File: rtl/down_counter.sv
// down_counter
//   Loadable down counter with one-shot or periodic (auto-reload) expiry.
//   A load arms the counter; a start in ARMED begins the countdown. The
//   expiry pulse is high for exactly the one cycle spent in DONE, and every
//   expiry is tallied in a wrapping event counter.
//
//   Ports:
//     clk            clock, rising edge
//     r_reset        synchronous active-high reset
//     i_load_valid   load request
//     o_load_ready   load can be accepted (IDLE/ARMED, not in reset)
//     i_load_value   terminal count N
//     i_auto_reload  periodic mode flag, sampled with the load
//     i_start        begin countdown (ARMED only)
//     i_stop         abort to IDLE, highest priority
//     o_count        current count
//     o_busy         high in RUN or DONE
//     o_expire       high while in DONE
//     o_exp_cnt      number of expiries, wrapping
module down_counter
    import down_counter_pkg::*;
#(
    parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH,
    parameter int EXP_CNT_WIDTH = DEF_EXP_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     r_reset,
    input  logic                     i_load_valid,
    output logic                     o_load_ready,
    input  logic [COUNT_WIDTH-1:0]   i_load_value,
    input  logic                     i_auto_reload,
    input  logic                     i_start,
    input  logic                     i_stop,
    output logic [COUNT_WIDTH-1:0]   o_count,
    output logic                     o_busy,
    output logic                     o_expire,
    output logic [EXP_CNT_WIDTH-1:0] o_exp_cnt
);

    state_t state, state_next;
    logic   auto_reload, auto_next;
    logic   load_fire;
    logic   dp_load, dp_dec, dp_reload, dp_clear;
    logic   cnt_zero, cnt_one, rl_zero;
    logic   load_zero;

    logic [EXP_CNT_WIDTH-1:0] exp_cnt;

    down_counter_dp #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_dp (
        .clk         (clk),
        .r_reset     (r_reset),
        .load        (dp_load),
        .load_value  (i_load_value),
        .dec         (dp_dec),
        .reload      (dp_reload),
        .clear       (dp_clear),
        .count       (o_count),
        .is_zero     (cnt_zero),
        .is_one      (cnt_one),
        .reload_zero (rl_zero)
    );

    assign o_load_ready = !r_reset && ((state == ST_IDLE) || (state == ST_ARMED));
    assign load_fire    = i_load_valid && o_load_ready;
    assign load_zero    = (i_load_value == '0);

    assign o_busy    = (state == ST_RUN) || (state == ST_DONE);
    assign o_expire  = (state == ST_DONE);
    assign o_exp_cnt = exp_cnt;

    always_ff @(posedge clk) begin
        if (r_reset) begin
            state       <= ST_IDLE;
            auto_reload <= 1'b0;
        end else begin
            state       <= state_next;
            auto_reload <= auto_next;
        end
    end

    // Every cycle in DONE is one expiry; it is counted on the edge leaving
    // DONE, including when i_stop forces that exit.
    always_ff @(posedge clk) begin
        if (r_reset) begin
            exp_cnt <= '0;
        end else if (state == ST_DONE) begin
            exp_cnt <= exp_cnt + EXP_CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state;
        auto_next  = auto_reload;
        dp_load    = 1'b0;
        dp_dec     = 1'b0;
        dp_reload  = 1'b0;
        dp_clear   = 1'b0;

        if (i_stop) begin
            state_next = ST_IDLE;
            auto_next  = 1'b0;
            dp_clear   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // start is ignored here, even alongside a load
                    if (load_fire) begin
                        dp_load    = 1'b1;
                        auto_next  = i_auto_reload;
                        state_next = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (load_fire) begin
                        dp_load   = 1'b1;
                        auto_next = i_auto_reload;
                    end
                    if (i_start) begin
                        // a same-edge load supplies the value the run starts from;
                        // a zero terminal count expires straight away
                        if (load_fire ? load_zero : cnt_zero) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    dp_dec = 1'b1;
                    if (cnt_one || cnt_zero) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (auto_reload) begin
                        dp_reload  = 1'b1;
                        state_next = rl_zero ? ST_DONE : ST_RUN;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;

    localparam int CW = 32;
    localparam int EW = 16;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          r_reset;
    logic          i_load_valid;
    logic          o_load_ready;
    logic [CW-1:0] i_load_value;
    logic          i_auto_reload;
    logic          i_start;
    logic          i_stop;
    logic [CW-1:0] o_count;
    logic          o_busy;
    logic          o_expire;
    logic [EW-1:0] o_exp_cnt;

    always #5 clk = ~clk;

    down_counter #(
        .COUNT_WIDTH   (CW),
        .EXP_CNT_WIDTH (EW)
    ) dut (
        .clk           (clk),
        .r_reset       (r_reset),
        .i_load_valid  (i_load_valid),
        .o_load_ready  (o_load_ready),
        .i_load_value  (i_load_value),
        .i_auto_reload (i_auto_reload),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .o_count       (o_count),
        .o_busy        (o_busy),
        .o_expire      (o_expire),
        .o_exp_cnt     (o_exp_cnt)
    );

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    bit chk_en = 1'b1;

    // reference model: mode, remaining count, reload value, periodic flag, expiries
    int            m_st  = M_IDLE;
    logic [CW-1:0] m_cnt = '0;
    logic [CW-1:0] m_rl  = '0;
    bit            m_au  = 1'b0;
    logic [EW-1:0] m_ec  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit lv, input logic [CW-1:0] v,
                         input bit ar, input bit st, input bit sp);
        r_reset       = rst;
        i_load_valid  = lv;
        i_load_value  = v;
        i_auto_reload = ar;
        i_start       = st;
        i_stop        = sp;
    endtask

    // Apply the spec's rules to the inputs seen at one rising edge.
    task automatic model_step();
        bit take;
        if (r_reset) begin
            m_st = M_IDLE; m_cnt = '0; m_rl = '0; m_au = 0; m_ec = '0;
        end else begin
            take = i_load_valid && (m_st == M_IDLE || m_st == M_ARMED);
            if (m_st == M_DONE) m_ec = m_ec + 1'b1;
            if (i_stop) begin
                m_st = M_IDLE; m_cnt = '0; m_au = 0;
            end else if (m_st == M_IDLE) begin
                if (take) begin
                    m_cnt = i_load_value; m_rl = i_load_value; m_au = i_auto_reload; m_st = M_ARMED;
                end
            end else if (m_st == M_ARMED) begin
                if (take) begin
                    m_cnt = i_load_value; m_rl = i_load_value; m_au = i_auto_reload;
                end
                if (i_start) m_st = (m_cnt == 0) ? M_DONE : M_RUN;
            end else if (m_st == M_RUN) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_st = M_DONE;
            end else begin
                if (m_au) begin
                    m_cnt = m_rl;
                    m_st  = (m_rl == 0) ? M_DONE : M_RUN;
                end else begin
                    m_st = M_IDLE;
                end
            end
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        #1;
        if (chk_en) check("load_ready", o_load_ready,
                          !r_reset && (m_st == M_IDLE || m_st == M_ARMED));
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk_en) begin
            check("count",   o_count,   m_cnt);
            check("busy",    o_busy,    (m_st == M_RUN || m_st == M_DONE));
            check("expire",  o_expire,  (m_st == M_DONE));
            check("exp_cnt", o_exp_cnt, m_ec);
        end
    endtask

    task automatic do_reset();
        drive(1, 0, '0, 0, 0, 0);
        cycle();
        drive(0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        int guard;
        int pulses;
        int last_pulse;
        int cyc;
        logic [EW-1:0] base;

        drive(1, 0, '0, 0, 0, 0);
        @(negedge clk);
        cycle();
        cycle();
        check("reset_count", o_count, 0);
        check("reset_busy", o_busy, 0);
        check("reset_exp_cnt", o_exp_cnt, 0);
        drive(0, 0, '0, 0, 0, 0);
        cycle();

        // one-shot: load 3, start, count 3,2,1,0 then IDLE
        drive(0, 1, 3, 0, 0, 0); cycle();
        check("armed_count", o_count, 3);
        drive(0, 0, '0, 0, 1, 0); cycle();
        check("run_count3", o_count, 3);
        drive(0, 0, '0, 0, 0, 0); cycle();
        check("run_count2", o_count, 2);
        cycle();
        check("run_count1", o_count, 1);
        check("no_early_expire", o_expire, 0);
        cycle();
        check("done_count0", o_count, 0);
        check("expire_3_edges", o_expire, 1);
        cycle();
        check("back_idle_busy", o_busy, 0);
        check("back_idle_expire", o_expire, 0);
        check("one_shot_exp_cnt", o_exp_cnt, 1);

        // start ignored in IDLE, load+start in IDLE only loads
        drive(0, 0, '0, 0, 1, 0); cycle();
        check("idle_start_ignored", o_busy, 0);
        drive(0, 1, 4, 0, 1, 0); cycle();
        check("idle_load_start_busy", o_busy, 0);
        check("idle_load_start_count", o_count, 4);
        // load and start together in ARMED runs with the new value
        drive(0, 1, 6, 0, 1, 0); cycle();
        check("armed_load_start_busy", o_busy, 1);
        check("armed_load_start_count", o_count, 6);
        drive(0, 0, '0, 0, 0, 1); cycle();

        // periodic: load 2 auto, expire every 3rd cycle
        base = o_exp_cnt;
        drive(0, 1, 2, 1, 0, 0); cycle();
        drive(0, 0, '0, 0, 1, 0); cycle();
        drive(0, 0, '0, 0, 0, 0);
        pulses = 0; last_pulse = -1; cyc = 0;
        while (pulses < 4 && cyc < 40) begin
            cycle();
            cyc++;
            if (o_expire) begin
                if (last_pulse >= 0) check("auto_period", cyc - last_pulse, 3);
                last_pulse = cyc;
                pulses++;
            end
        end
        check("auto_pulses_seen", pulses, 4);
        cycle();
        check("auto_exp_cnt", o_exp_cnt - base, 4);
        drive(0, 0, '0, 0, 0, 1); cycle();

        // zero load: start goes straight to DONE; auto keeps it there until stop
        drive(0, 1, 0, 1, 0, 0); cycle();
        drive(0, 0, '0, 0, 1, 0); cycle();
        check("zero_done_next_edge", o_expire, 1);
        drive(0, 0, '0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("zero_auto_expire", o_expire, 1);
        end
        drive(0, 0, '0, 0, 0, 1); cycle();
        check("zero_stop_expire", o_expire, 0);
        check("zero_stop_busy", o_busy, 0);
        drive(0, 0, '0, 0, 0, 0); cycle();

        // stop + load at count 50 of a 100 run
        drive(0, 1, 100, 0, 0, 0); cycle();
        drive(0, 0, '0, 0, 1, 0); cycle();
        drive(0, 0, '0, 0, 0, 0);
        guard = 0;
        while (o_count != 50 && guard < 200) begin
            cycle();
            guard++;
        end
        check("reach_count50", o_count, 50);
        drive(0, 1, 7, 1, 0, 1); cycle();
        check("stop_count", o_count, 0);
        check("stop_busy", o_busy, 0);
        check("stop_expire", o_expire, 0);
        drive(0, 0, '0, 0, 0, 0); cycle();
        check("stop_no_load", o_count, 0);

        // reset mid-run at count 5 of a 10 run
        do_reset();
        drive(0, 1, 10, 0, 0, 0); cycle();
        drive(0, 0, '0, 0, 1, 0); cycle();
        drive(0, 0, '0, 0, 0, 0);
        guard = 0;
        while (o_count != 5 && guard < 50) begin
            cycle();
            guard++;
        end
        check("reach_count5", o_count, 5);
        drive(1, 0, '0, 0, 0, 0); cycle();
        check("rst_count", o_count, 0);
        check("rst_busy", o_busy, 0);
        check("rst_expire", o_expire, 0);
        check("rst_exp_cnt", o_exp_cnt, 0);
        drive(0, 0, '0, 0, 0, 0);
        #1;
        check("rst_ready_after", o_load_ready, 1);
        cycle();
        check("rst_no_late_expire", o_expire, 0);

        // exp_cnt wrap: expire every cycle up to FFFF, then one more
        drive(0, 1, 0, 1, 0, 0); cycle();
        drive(0, 0, '0, 0, 1, 0); cycle();
        drive(0, 0, '0, 0, 0, 0);
        chk_en = 1'b0;
        guard = 0;
        while (m_ec != 16'hFFFF && guard < 70000) begin
            cycle();
            guard++;
        end
        chk_en = 1'b1;
        check("exp_cnt_ffff", o_exp_cnt, 16'hFFFF);
        cycle();
        check("exp_cnt_wrap", o_exp_cnt, 0);
        drive(0, 0, '0, 0, 0, 1); cycle();

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 30),
                  CW'($urandom_range(0, 6)),
                  $urandom_range(0, 1),
                  ($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 99) < 5));
            cycle();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
